// File: rtl/bitplane_sequencer_if.sv
// Job and engine-array handshake bundle for bitplane_sequencer.
// The master drives the job request and the engine-side ready; the slave is the sequencer.
interface bitplane_sequencer_if #(
    parameter int NUM_ENGINES = 8,
    parameter int SLICE_W     = 4,
    parameter int WEIGHT_BITS = 5,
    parameter int LANES       = 4,
    parameter int LANE_W      = 16,
    parameter int PLANE_W     = NUM_ENGINES * SLICE_W,
    parameter int SHIFT_W     = $clog2(WEIGHT_BITS),
    parameter int CFG_W       = $clog2(WEIGHT_BITS + 1)
);
    logic                                  start;
    logic                                  in_ready;
    logic [WEIGHT_BITS*PLANE_W-1:0]        weight_in;
    logic [NUM_ENGINES*LANES*LANE_W-1:0]   data_in;
    logic [CFG_W-1:0]                      cfg_bits;
    logic                                  skip_en;
    logic                                  slice_valid;
    logic                                  slice_ready;
    logic [PLANE_W-1:0]                    slice_weight;
    logic [NUM_ENGINES*LANES*LANE_W-1:0]   slice_data;
    logic [NUM_ENGINES*SHIFT_W-1:0]        shift_out;
    logic [NUM_ENGINES-1:0]                slice_zero_mask;
    logic                                  slice_first;
    logic                                  slice_last;
    logic                                  busy;
    logic                                  done;
    logic [SHIFT_W:0]                      skip_count;

    modport master (
        output start, weight_in, data_in, cfg_bits, skip_en, slice_ready,
        input  in_ready, slice_valid, slice_weight, slice_data, shift_out,
               slice_zero_mask, slice_first, slice_last, busy, done, skip_count
    );

    modport slave (
        input  start, weight_in, data_in, cfg_bits, skip_en, slice_ready,
        output in_ready, slice_valid, slice_weight, slice_data, shift_out,
               slice_zero_mask, slice_first, slice_last, busy, done, skip_count
    );
endinterface

// File: rtl/bitplane_sequencer.sv
// Latches one weight/data job and steps its eligible bit-planes, lowest first,
// to the engine array over a valid/ready handshake.
module bitplane_sequencer #(
    parameter int NUM_ENGINES = 8,
    parameter int SLICE_W     = 4,
    parameter int WEIGHT_BITS = 5,
    parameter int LANES       = 4,
    parameter int LANE_W      = 16,
    parameter int PLANE_W     = NUM_ENGINES * SLICE_W,
    parameter int SHIFT_W     = $clog2(WEIGHT_BITS),
    parameter int CFG_W       = $clog2(WEIGHT_BITS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    bitplane_sequencer_if.slave bus
);
    localparam int IDX_W  = SHIFT_W + 1;
    localparam int WGT_W  = WEIGHT_BITS * PLANE_W;
    localparam int DATA_W = NUM_ENGINES * LANES * LANE_W;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic [WGT_W-1:0]   r_weight;
    logic [DATA_W-1:0]  r_data;
    logic               r_skip_en;
    logic [CFG_W-1:0]   r_n;
    logic [SHIFT_W-1:0] r_ptr;
    logic [IDX_W-1:0]   r_skip_count;
    logic               r_first;

    logic [CFG_W-1:0]       w_n_in;
    logic [WEIGHT_BITS-1:0] w_mask_in;
    logic [WEIGHT_BITS-1:0] w_mask_r;
    logic [IDX_W-1:0]       w_first_in;
    logic [IDX_W-1:0]       w_ptr_inc;
    logic [IDX_W-1:0]       w_next;
    logic                   w_any_in;
    logic                   w_last;
    logic                   w_accept;
    logic                   w_xfer;
    logic [PLANE_W-1:0]     w_plane;
    logic [NUM_ENGINES-1:0] w_zero_mask;

    // A plane is eligible when it lies below the plane count and is not an all-zero plane being skipped.
    function automatic logic [WEIGHT_BITS-1:0] elig_mask(
        input logic [WGT_W-1:0] w,
        input logic [CFG_W-1:0] n,
        input logic             skip
    );
        logic [WEIGHT_BITS-1:0] m;
        for (int b = 0; b < WEIGHT_BITS; b++) begin
            m[b] = (b < int'(n)) && !(skip && (w[b*PLANE_W +: PLANE_W] == {PLANE_W{1'b0}}));
        end
        return m;
    endfunction

    // Lowest eligible index at or above 'from'; returns n when none remains, so
    // (result - from) is always the number of planes passed over.
    function automatic logic [IDX_W-1:0] next_elig(
        input logic [WEIGHT_BITS-1:0] m,
        input logic [IDX_W-1:0]       from,
        input logic [CFG_W-1:0]       n
    );
        logic [IDX_W-1:0] r;
        r = IDX_W'(n);
        for (int b = WEIGHT_BITS - 1; b >= 0; b--) begin
            if (m[b] && (b >= int'(from))) begin
                r = IDX_W'(b);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Job-acceptance and plane-advance decode.
    always_comb begin
        w_n_in = bus.cfg_bits;
        if (int'(bus.cfg_bits) > WEIGHT_BITS) begin
            w_n_in = CFG_W'(WEIGHT_BITS);
        end else begin
            w_n_in = bus.cfg_bits;
        end
        w_mask_in  = elig_mask(bus.weight_in, w_n_in, bus.skip_en);
        w_first_in = next_elig(w_mask_in, {IDX_W{1'b0}}, w_n_in);
        w_any_in   = (w_first_in < IDX_W'(w_n_in));
        w_mask_r   = elig_mask(r_weight, r_n, r_skip_en);
        w_ptr_inc  = IDX_W'(r_ptr) + {{SHIFT_W{1'b0}}, 1'b1};
        w_next     = next_elig(w_mask_r, w_ptr_inc, r_n);
        w_last     = (w_next >= IDX_W'(r_n));
        w_accept   = bus.start && (r_state == S_IDLE);
        w_xfer     = (r_state == S_RUN) && bus.slice_ready;
    end

    // FSM next-state and done pulse.
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_any_in) begin
                    w_state_nxt = S_RUN;
                end else if (w_accept) begin
                    w_done_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_xfer && w_last) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state and done registers.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Job latch, plane pointer and skip accounting.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_weight     <= {WGT_W{1'b0}};
            r_data       <= {DATA_W{1'b0}};
            r_skip_en    <= 1'b0;
            r_n          <= {CFG_W{1'b0}};
            r_ptr        <= {SHIFT_W{1'b0}};
            r_skip_count <= {IDX_W{1'b0}};
            r_first      <= 1'b0;
        end else if (w_accept) begin
            r_weight     <= bus.weight_in;
            r_data       <= bus.data_in;
            r_skip_en    <= bus.skip_en;
            r_n          <= w_n_in;
            r_ptr        <= w_any_in ? w_first_in[SHIFT_W-1:0] : {SHIFT_W{1'b0}};
            r_skip_count <= w_first_in;
            r_first      <= w_any_in;
        end else if (w_xfer) begin
            r_first      <= 1'b0;
            r_skip_count <= r_skip_count + (w_next - w_ptr_inc);
            r_ptr        <= w_last ? r_ptr : w_next[SHIFT_W-1:0];
        end else begin
            r_first      <= r_first;
            r_ptr        <= r_ptr;
            r_skip_count <= r_skip_count;
        end
    end

    // Presentation is decoded from registers only; everything reads zero outside RUN.
    always_comb begin
        w_plane     = r_weight[r_ptr*PLANE_W +: PLANE_W];
        w_zero_mask = {NUM_ENGINES{1'b0}};
        for (int j = 0; j < NUM_ENGINES; j++) begin
            w_zero_mask[j] = (w_plane[j*SLICE_W +: SLICE_W] == {SLICE_W{1'b0}});
        end
        if (r_state == S_RUN) begin
            bus.slice_weight    = w_plane;
            bus.shift_out       = {NUM_ENGINES{r_ptr}};
            bus.slice_zero_mask = w_zero_mask;
            bus.slice_first     = r_first;
            bus.slice_last      = w_last;
        end else begin
            bus.slice_weight    = {PLANE_W{1'b0}};
            bus.shift_out       = {(NUM_ENGINES*SHIFT_W){1'b0}};
            bus.slice_zero_mask = {NUM_ENGINES{1'b0}};
            bus.slice_first     = 1'b0;
            bus.slice_last      = 1'b0;
        end
    end

    assign bus.in_ready    = (r_state == S_IDLE);
    assign bus.slice_valid = (r_state == S_RUN);
    assign bus.busy        = (r_state == S_RUN);
    assign bus.done        = r_done;
    assign bus.slice_data  = r_data;
    assign bus.skip_count  = r_skip_count;
endmodule

// File: doc/bitplane_sequencer.md
Name: bitplane_sequencer

Overview:
- Parametrised successor of the fixed 8-engine, 5-plane bit-serial weight slicer.
- Latches one job (packed weight bit-planes S plus per-engine A data) through a start/in_ready handshake, then steps the bit-planes to the engine array through a valid/ready handshake.
- Adds a configurable plane count, optional skipping of all-zero planes, per-engine zero masks, and done/busy status.
- Sits between the operand fetch logic and the engine array.

Parameters:
- NUM_ENGINES, 8, number of engines fed in parallel.
- SLICE_W, 4, weight bits per engine per plane.
- WEIGHT_BITS, 5, maximum number of bit-planes per job.
- LANES, 4, data lanes per engine.
- LANE_W, 16, bits per data lane.
- PLANE_W, NUM_ENGINES*SLICE_W, derived; width of one plane.
- SHIFT_W, $clog2(WEIGHT_BITS), derived; width of the plane index.
- CFG_W, $clog2(WEIGHT_BITS+1), derived; width of cfg_bits.

Ports:
- clk  input  1  clock, all state on the rising edge.
- rst_n  input  1  asynchronous, active-high reset (name kept from the codebase; asserted = 1).
- start  input  1  job request; accepted when start && in_ready.
- in_ready  output  1  high in IDLE.
- weight_in  input  WEIGHT_BITS*PLANE_W  plane b at [b*PLANE_W +: PLANE_W]; engine j's share of a plane at [j*SLICE_W +: SLICE_W].
- data_in  input  NUM_ENGINES*LANES*LANE_W  engine j's data at [j*LANES*LANE_W +: LANES*LANE_W].
- cfg_bits  input  CFG_W  number of planes to process, sampled at accept.
- skip_en  input  1  skip all-zero planes, sampled at accept.
- slice_valid  output  1  current plane is presented.
- slice_ready  input  1  engine array consumes the plane.
- slice_weight  output  PLANE_W  current plane.
- slice_data  output  NUM_ENGINES*LANES*LANE_W  latched data, constant for the whole job.
- shift_out  output  NUM_ENGINES*SHIFT_W  current plane index, replicated per engine.
- slice_zero_mask  output  NUM_ENGINES  bit j = 1 when engine j's SLICE_W bits are all zero.
- slice_first  output  1  first presented plane of the job.
- slice_last  output  1  no further plane will be presented in this job.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when the job completes.
- skip_count  output  SHIFT_W+1  number of planes skipped in the last job.

Behaviour:
- Reset values (rst_n = 1, asynchronous): state = IDLE; slice_valid, busy, done, slice_first, slice_last = 0; all latched registers, skip_count and shift_out = 0.
- Reset asserted mid-job aborts the job immediately and produces no done pulse.
- FSM states:
  - IDLE: in_ready = 1.
  - RUN: slice_valid = 1, busy = 1.
- Accept: start && in_ready at edge t.
  - Latches weight_in, data_in and skip_en.
  - Latches n = min(cfg_bits, WEIGHT_BITS).
  - Clears skip_count.
- Eligible planes: indices 0..n-1. When skip_en = 1, a plane whose PLANE_W bits are all zero is not eligible.
- If no plane is eligible (n = 0, or all planes zero with skip_en = 1):
  - State stays IDLE.
  - done = 1 in cycle t+1; no slice_valid.
  - skip_count = number of zero planes skipped.
- Otherwise:
  - The FSM enters RUN with the plane pointer at the lowest eligible index.
  - slice_valid rises in cycle t+1.
- Presentation: slice_weight, shift_out, slice_zero_mask, slice_first and slice_last are decoded from registered state and the plane pointer only, with no input-to-output combinational path.
- Payload is held stable while slice_valid && !slice_ready.
- On a transfer (slice_valid && slice_ready):
  - If slice_last = 0: the pointer advances to the next eligible index.
  - If slice_last = 1: state returns to IDLE, done = 1 and in_ready = 1 in the following cycle.
  - A start in that done cycle is accepted, giving back-to-back jobs.
- skip_count increments by the number of ineligible planes passed over. It holds after done until the next accept.
- Throughput: one plane per cycle with slice_ready held high. A job with k eligible planes has done at t+1+k.
- start while busy is ignored and not queued.
- cfg_bits > WEIGHT_BITS is clamped to WEIGHT_BITS.
- Planes are scanned in ascending order only.

Test Plan:
1. Defaults, cfg_bits=5, skip_en=0, every plane 0x11111111, slice_ready=1, accept at t -> five slices with shift_out 0,1,2,3,4; slice_first on shift 0; slice_last on shift 4; done at t+6; slice_zero_mask=0x00.
2. Planes 1 and 3 = 0, plane 0 = 0x0000000F, skip_en=1, cfg_bits=5 -> slices with shift 0,2,4; plane-0 slice_zero_mask=0xFE; skip_count=2; done at t+4.
3. Same job as 2 with skip_en=0 -> five slices, planes 1 and 3 presented as 0x00000000 with mask 0xFF; skip_count=0.
4. slice_ready low for 3 cycles while plane 2 is presented -> slice_valid held; slice_weight and shift_out=2 stable; no advance; done delayed by 3 cycles.
5. cfg_bits=0 -> no slice_valid, done at t+1. cfg_bits=7 -> clamped, exactly 5 slices. start pulsed during RUN -> ignored. start in the done cycle -> accepted, first slice the next cycle.
6. rst_n asserted during plane 3 -> slice_valid, busy and shift_out drop to 0 asynchronously; no done; after release a new job runs normally from plane 0.
